// File: rtl/tk_ctrl.sv
// tk_ctrl: register-mapped control block with identity words, CDI storage, debounced GPIO and LED control.
// Optional LED PWM is compiled only when TK_CTRL_LED_PWM_EN is defined.
module tk_ctrl #(
  parameter int          NUM_GPIO_IN     = 2,
  parameter int          NUM_GPIO_OUT    = 2,
  parameter int          CDI_WORDS       = 8,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          PWM_WIDTH       = 8,
  parameter logic [31:0] UDI0            = 32'h0,
  parameter logic [31:0] UDI1            = 32'h0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cs,
  input  logic                    we,
  input  logic [7:0]              address,
  input  logic [31:0]             write_data,
  output logic [31:0]             read_data,
  output logic                    ready,
  output logic                    fw_app_mode,
  output logic [2:0]              led,
  input  logic [NUM_GPIO_IN-1:0]  gpio_in,
  output logic [NUM_GPIO_OUT-1:0] gpio_out
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic                    wr;
  logic                    app_mode_reg;
  logic [2:0]              mask_reg;
  logic [31:0]             app_start_reg;
  logic [31:0]             app_size_reg;
  logic [31:0]             debug_reg;
  logic [NUM_GPIO_OUT-1:0] gpio_out_reg;
  logic [NUM_GPIO_IN-1:0]  sync1_reg;
  logic [NUM_GPIO_IN-1:0]  sync2_reg;
  logic [NUM_GPIO_IN-1:0]  db_reg;
  logic [NUM_GPIO_IN-1:0]  db_next;
  logic [NUM_GPIO_IN-1:0]  event_reg;
  logic [NUM_GPIO_IN-1:0]  event_next;
  logic [NUM_GPIO_IN-1:0]  event_clr;
  logic [NUM_GPIO_IN-1:0]  flip;
  logic [NUM_GPIO_IN-1:0]  rise;
  logic [7:0]              cnt_reg  [NUM_GPIO_IN];
  logic [7:0]              cnt_next [NUM_GPIO_IN];
  logic [31:0]             cdi_word [8];
  logic [31:0]             duty_rd;
  logic [31:0]             rd;

  assign wr          = cs & we;
  assign ready       = cs;
  assign fw_app_mode = app_mode_reg;
  assign gpio_out    = gpio_out_reg;
  assign read_data   = rd;

  // Per-pin debounce: the bit flips on the cycle the mismatch counter would reach DEBOUNCE_CYCLES.
  for (genvar gi = 0; gi < NUM_GPIO_IN; gi++) begin : g_db
    assign flip[gi]     = (sync2_reg[gi] != db_reg[gi]) && (cnt_reg[gi] == DB_LAST);
    assign cnt_next[gi] = ((sync2_reg[gi] != db_reg[gi]) && !flip[gi]) ? cnt_reg[gi] + 8'd1 : 8'd0;
  end

  assign db_next    = db_reg ^ flip;
  assign rise       = flip & ~db_reg;
  assign event_clr  = (wr && address == 8'h0e) ? write_data[NUM_GPIO_IN-1:0] : '0;
  assign event_next = (event_reg & ~event_clr) | rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      app_mode_reg  <= 1'b0;
      mask_reg      <= 3'b110;
      app_start_reg <= '0;
      app_size_reg  <= '0;
      debug_reg     <= '0;
      gpio_out_reg  <= '0;
      sync1_reg     <= '0;
      sync2_reg     <= '0;
      db_reg        <= '0;
      event_reg     <= '0;
      for (int i = 0; i < NUM_GPIO_IN; i++) cnt_reg[i] <= 8'd0;
    end else begin
      sync1_reg <= gpio_in;
      sync2_reg <= sync1_reg;
      db_reg    <= db_next;
      event_reg <= event_next;
      for (int i = 0; i < NUM_GPIO_IN; i++) cnt_reg[i] <= cnt_next[i];
      if (wr) begin
        case (address)
          8'h08: app_mode_reg <= 1'b1;
          8'h09: mask_reg     <= write_data[2:0];
          8'h0b: gpio_out_reg <= write_data[NUM_GPIO_OUT-1:0];
          8'h0c: if (!app_mode_reg) app_start_reg <= write_data;
          8'h0d: if (!app_mode_reg) app_size_reg  <= write_data;
          8'h10: debug_reg    <= write_data;
          default: ;
        endcase
      end
    end
  end

  // CDI words are locked once the device has entered app mode.
  for (genvar gi = 0; gi < 8; gi++) begin : g_cdi
    if (gi < CDI_WORDS) begin : g_on
      logic [31:0] word_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          word_reg <= '0;
        end else if (wr && !app_mode_reg && address == 8'(32 + gi)) begin
          word_reg <= write_data;
        end
      end
      assign cdi_word[gi] = word_reg;
    end else begin : g_off
      assign cdi_word[gi] = '0;
    end
  end

`ifdef TK_CTRL_LED_PWM_EN
  logic [PWM_WIDTH-1:0] pwm_cnt_reg;
  logic [PWM_WIDTH-1:0] duty_reg [3];

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_reg <= '0;
      for (int i = 0; i < 3; i++) duty_reg[i] <= '1;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      if (wr && address == 8'h14) duty_reg[2] <= write_data[PWM_WIDTH-1:0];
      if (wr && address == 8'h15) duty_reg[1] <= write_data[PWM_WIDTH-1:0];
      if (wr && address == 8'h16) duty_reg[0] <= write_data[PWM_WIDTH-1:0];
    end
  end

  // An all-ones duty means fully on, so the LED never blinks at maximum brightness.
  for (genvar gi = 0; gi < 3; gi++) begin : g_led
    assign led[gi] = mask_reg[gi] & ((&duty_reg[gi]) | (pwm_cnt_reg < duty_reg[gi]));
  end

  always_comb begin
    duty_rd = '0;
    case (address)
      8'h14:   duty_rd[PWM_WIDTH-1:0] = duty_reg[2];
      8'h15:   duty_rd[PWM_WIDTH-1:0] = duty_reg[1];
      8'h16:   duty_rd[PWM_WIDTH-1:0] = duty_reg[0];
      default: duty_rd = '0;
    endcase
  end
`else
  assign led     = mask_reg;
  assign duty_rd = '0;
`endif

  always_comb begin
    rd = '0;
    if (cs && !we) begin
      case (address)
        8'h00: rd = 32'h746b3163;
        8'h01: rd = 32'h6d6b6466;
        8'h02: rd = 32'h00000005;
        8'h03: rd = {8'h00, 8'(CDI_WORDS), 8'(NUM_GPIO_OUT), 8'(NUM_GPIO_IN)};
        8'h08: rd = {32{app_mode_reg}};
        8'h09: rd[2:0] = mask_reg;
        8'h0a: rd[NUM_GPIO_IN-1:0] = db_reg;
        8'h0b: rd[NUM_GPIO_OUT-1:0] = gpio_out_reg;
        8'h0c: rd = app_start_reg;
        8'h0d: rd = app_size_reg;
        8'h0e: rd[NUM_GPIO_IN-1:0] = event_reg;
        8'h10: rd = debug_reg;
        8'h14, 8'h15, 8'h16: rd = duty_rd;
        8'h30: rd = UDI0;
        8'h31: rd = UDI1;
        default: if (address[7:3] == 5'h04) rd = cdi_word[address[2:0]];
      endcase
    end
  end

endmodule

// File: tb/tb_tk_ctrl.sv
// Directed self-checking bench for tk_ctrl; read expectations go through a scoreboard queue.
module tb_tk_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        fw_app_mode;
  logic [2:0]  led;
  logic [1:0]  gpio_in;
  logic [1:0]  gpio_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  tk_ctrl #(
    .NUM_GPIO_IN(2), .NUM_GPIO_OUT(2), .CDI_WORDS(8), .DEBOUNCE_CYCLES(4),
    .PWM_WIDTH(4), .UDI0(32'h12345678), .UDI1(32'h9abcdef0)
  ) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .fw_app_mode(fw_app_mode), .led(led), .gpio_in(gpio_in), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Push the expected word, present the read, then pop and compare the combinational result.
  task automatic rd(input logic [7:0] a, input logic [31:0] expv, input string tag);
    logic [31:0] e;
    exp_q.push_back(expv);
    cs = 1'b1; we = 1'b0; address = a;
    #1;
    e = exp_q.pop_front();
    chk(tag, read_data, e);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    cs = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0; write_data = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs;
    reset = 1'b1; cs = 1'b0; we = 1'b0; address = '0; write_data = '0; gpio_in = 2'b00;
    tick(); tick();
    reset = 1'b0;

    // Reset state and identity registers
    chk("rst_led", {29'd0, led}, 32'h6);
    chk("rst_app", {31'd0, fw_app_mode}, 32'd0);
    chk("rst_gpio_out", {30'd0, gpio_out}, 32'd0);
    chk("idle_ready", {31'd0, ready}, 32'd0);
    chk("idle_rdata", read_data, 32'd0);
    rd(8'h00, 32'h746b3163, "id0");
    rd(8'h01, 32'h6d6b6466, "id1");
    rd(8'h02, 32'h00000005, "id2");
    rd(8'h03, 32'h00080202, "id3");
    rd(8'h30, 32'h12345678, "udi0");
    rd(8'h31, 32'h9abcdef0, "udi1");
    rd(8'h40, 32'h0, "unmapped");
    rd(8'h09, 32'h6, "rst_mask");
    rd(8'h0a, 32'h0, "rst_gpio_in");

    // CDI lock once in app mode
    wr(8'h23, 32'hdeadbeef);
    rd(8'h23, 32'hdeadbeef, "cdi3_wr");
    cs = 1'b1; we = 1'b1; address = 8'h08; write_data = 32'h0;
    #1;
    chk("rdata_on_write", read_data, 32'd0);
    chk("ready_on_write", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0;
    chk("app_mode_set", {31'd0, fw_app_mode}, 32'd1);
    rd(8'h08, 32'hffffffff, "app_mode_rd");
    wr(8'h23, 32'h1);
    wr(8'h0d, 32'h100);
    wr(8'h0c, 32'h55);
    rd(8'h23, 32'hdeadbeef, "cdi3_locked");
    rd(8'h0d, 32'h0, "app_size_locked");
    rd(8'h0c, 32'h0, "app_start_locked");
    wr(8'h30, 32'h0);
    rd(8'h30, 32'h12345678, "udi0_ro");

    // Plain read/write registers and width truncation
    wr(8'h10, 32'ha5a5a5a5);
    rd(8'h10, 32'ha5a5a5a5, "debug");
    wr(8'h0b, 32'hffffffff);
    chk("gpio_out_pins", {30'd0, gpio_out}, 32'h3);
    rd(8'h0b, 32'h3, "gpio_out_rd");
    wr(8'h09, 32'hfffffff9);
    rd(8'h09, 32'h1, "mask_rd");

    // Glitch shorter than the debounce window
    gpio_in = 2'b01;
    tick(); tick(); tick();
    gpio_in = 2'b00;
    for (int n = 1; n <= 10; n++) begin
      tick();
      rd(8'h0a, 32'h0, "glitch");
    end
    rd(8'h0e, 32'h0, "glitch_event");

    // Stable rise: visible exactly 6 cycles after the pin change
    gpio_in = 2'b01;
    for (int n = 1; n <= 6; n++) begin
      tick();
      rd(8'h0a, (n >= 6) ? 32'h1 : 32'h0, $sformatf("rise_c%0d", n));
    end
    rd(8'h0e, 32'h1, "rise_event");
    tick(); tick(); tick(); tick();

    // Falling edge leaves the event alone; then clear coincides with a new rise
    gpio_in = 2'b00;
    for (int n = 0; n < 8; n++) tick();
    rd(8'h0a, 32'h0, "fall");
    rd(8'h0e, 32'h1, "fall_event_kept");
    gpio_in = 2'b01;
    for (int n = 0; n < 5; n++) tick();
    rd(8'h0a, 32'h0, "pre_rise2");
    wr(8'h0e, 32'hffffffff);
    rd(8'h0a, 32'h1, "rise2");
    rd(8'h0e, 32'h1, "set_wins");
    wr(8'h0e, 32'h1);
    rd(8'h0e, 32'h0, "event_cleared");

`ifdef TK_CTRL_LED_PWM_EN
    wr(8'h09, 32'h1);
    wr(8'h16, 32'h4);
    rd(8'h16, 32'h4, "duty_b_rd");
    highs = 0;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (led[0]) highs++;
      chk("pwm_rg_off", {29'd0, led[2:1], 1'b0}, 32'd0);
    end
    chk("pwm_duty4", highs, 32'd4);
    wr(8'h16, 32'hf);
    highs = 0;
    for (int n = 0; n < 16; n++) begin tick(); if (led[0]) highs++; end
    chk("pwm_duty15", highs, 32'd16);
    wr(8'h16, 32'h0);
    highs = 0;
    for (int n = 0; n < 16; n++) begin tick(); if (led[0]) highs++; end
    chk("pwm_duty0", highs, 32'd0);
    wr(8'h14, 32'h3);
    rd(8'h14, 32'h3, "duty_r_rd");
`else
    wr(8'h09, 32'h5);
    chk("led_mask", {29'd0, led}, 32'h5);
    wr(8'h16, 32'h4);
    rd(8'h16, 32'h0, "duty_absent");
    highs = 0;
    for (int n = 0; n < 16; n++) begin tick(); if (led[0]) highs++; end
    chk("led_steady", highs, 32'd16);
`endif

    // Reset mid-debounce on pin 1
    gpio_in = 2'b10;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_led", {29'd0, led}, 32'h6);
    chk("rst2_app", {31'd0, fw_app_mode}, 32'd0);
    chk("rst2_gpio_out", {30'd0, gpio_out}, 32'd0);
    rd(8'h0e, 32'h0, "rst2_event");
    rd(8'h0d, 32'h0, "rst2_app_size");
    rd(8'h23, 32'h0, "rst2_cdi3");
    rd(8'h10, 32'h0, "rst2_debug");
    rd(8'h09, 32'h6, "rst2_mask");
`ifdef TK_CTRL_LED_PWM_EN
    rd(8'h14, 32'hf, "rst2_duty_r");
    rd(8'h16, 32'hf, "rst2_duty_b");
`endif
    for (int n = 1; n <= 6; n++) begin
      tick();
      rd(8'h0a, (n >= 6) ? 32'h2 : 32'h0, $sformatf("requal_c%0d", n));
    end
    rd(8'h0e, 32'h2, "requal_event");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
